// File: rtl/regression_train_sequencer_pkg.sv
// Shared definitions for the regression training sequencer, its loop counters,
// and the loader/MAC blocks it drives.
package regression_train_sequencer_pkg;

  localparam int NUM_FEATURES_DEF = 4;
  localparam int FEAT_W_DEF       = 2;
  localparam int NUM_EPOCHS_DEF   = 3;
  localparam int EPOCH_W_DEF      = 2;
  localparam int SAMP_W_DEF       = 10;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ARM       = 4'd1,
    ST_INIT      = 4'd2,
    ST_REQ       = 4'd3,
    ST_WAIT      = 4'd4,
    ST_MAC       = 4'd5,
    ST_ERR       = 4'd6,
    ST_ACC       = 4'd7,
    ST_EPOCH_END = 4'd8,
    ST_UPDATE    = 4'd9,
    ST_DONE      = 4'd10
  } state_t;

endpackage

// File: rtl/regression_train_sequencer_train_loop_counters.sv
// Feature, sample and epoch registers for the training loop; the FSM drives
// clr/inc and reads back the terminal-index flags.
module train_loop_counters #(
  parameter int NUM_FEATURES = 4,
  parameter int FEAT_W       = 2,
  parameter int NUM_EPOCHS   = 3,
  parameter int EPOCH_W      = 2,
  parameter int SAMP_W       = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               feat_clr,
  input  logic               feat_inc,
  input  logic               samp_clr,
  input  logic               samp_inc,
  input  logic               epoch_clr,
  input  logic               epoch_inc,
  output logic [FEAT_W-1:0]  feat_idx,
  output logic [SAMP_W-1:0]  sample_cnt,
  output logic [EPOCH_W-1:0] epoch_idx,
  output logic               feat_last,
  output logic               epoch_last
);

  localparam logic [FEAT_W-1:0]  FEAT_MAX  = FEAT_W'(NUM_FEATURES - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_MAX = EPOCH_W'(NUM_EPOCHS - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         feat_idx <= '0;
    else if (feat_clr)  feat_idx <= '0;
    else if (feat_inc)  feat_idx <= feat_idx + 1'b1;
  end

  // Saturates so a huge dataset cannot wrap back to the "empty" count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              sample_cnt <= '0;
    else if (samp_clr)                       sample_cnt <= '0;
    else if (samp_inc && (sample_cnt != '1)) sample_cnt <= sample_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         epoch_idx <= '0;
    else if (epoch_clr) epoch_idx <= '0;
    else if (epoch_inc) epoch_idx <= epoch_idx + 1'b1;
  end

  assign feat_last  = (feat_idx == FEAT_MAX);
  assign epoch_last = (epoch_idx >= EPOCH_MAX);

endmodule

// File: rtl/regression_train_sequencer.sv
// Multi-epoch training sequencer: fetch sample, step the MAC, error, accumulate,
// and weight update at each end of dataset.
//   state     | meaning
//   IDLE/ARM  | ready; run launches when start falls
//   INIT      | rewind loader, clear error accumulator
//   REQ/WAIT  | request a sample, wait for data_valid or eof
//   MAC       | step feat_idx through all coefficients
//   ERR/ACC   | compute and accumulate the sample error
//   EPOCH_END | skip the update on an empty dataset
//   UPDATE    | apply weight update, then next epoch or DONE
//   DONE      | one-cycle completion pulse
module regression_train_sequencer
  import regression_train_sequencer_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int FEAT_W       = FEAT_W_DEF,
  parameter int NUM_EPOCHS   = NUM_EPOCHS_DEF,
  parameter int EPOCH_W      = EPOCH_W_DEF,
  parameter int SAMP_W       = SAMP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               eof,
  input  logic               data_valid,
  output logic               ready,
  output logic               busy,
  output logic               init_dl,
  output logic               init_ec,
  output logic               next,
  output logic               clr_mac,
  output logic               en_mac,
  output logic [FEAT_W-1:0]  feat_idx,
  output logic               en_err,
  output logic               en_acc,
  output logic               en_update,
  output logic               done,
  output logic [SAMP_W-1:0]  sample_cnt,
  output logic [EPOCH_W-1:0] epoch_idx
);

  state_t state, state_nxt;
  logic   feat_clr, feat_inc, samp_clr, samp_inc, epoch_clr, epoch_inc;
  logic   feat_last, epoch_last, epoch_check;

  train_loop_counters #(
    .NUM_FEATURES(NUM_FEATURES),
    .FEAT_W      (FEAT_W),
    .NUM_EPOCHS  (NUM_EPOCHS),
    .EPOCH_W     (EPOCH_W),
    .SAMP_W      (SAMP_W)
  ) u_counters (
    .clk       (clk),
    .reset     (reset),
    .feat_clr  (feat_clr),
    .feat_inc  (feat_inc),
    .samp_clr  (samp_clr),
    .samp_inc  (samp_inc),
    .epoch_clr (epoch_clr),
    .epoch_inc (epoch_inc),
    .feat_idx  (feat_idx),
    .sample_cnt(sample_cnt),
    .epoch_idx (epoch_idx),
    .feat_last (feat_last),
    .epoch_last(epoch_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    feat_clr    = 1'b0;
    feat_inc    = 1'b0;
    samp_clr    = 1'b0;
    samp_inc    = 1'b0;
    epoch_clr   = 1'b0;
    epoch_inc   = 1'b0;
    epoch_check = 1'b0;

    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_ARM;
      ST_ARM: begin
        // Epoch restarts only on a fresh launch, never on an epoch rollover.
        if (!start) begin
          state_nxt = ST_INIT;
          epoch_clr = 1'b1;
        end
      end
      ST_INIT: begin
        samp_clr  = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (data_valid) state_nxt = ST_MAC;
        else if (eof)   state_nxt = ST_EPOCH_END;
      end
      ST_MAC: begin
        if (feat_last) begin
          feat_clr  = 1'b1;
          state_nxt = ST_ERR;
        end else begin
          feat_inc = 1'b1;
        end
      end
      ST_ERR: state_nxt = ST_ACC;
      ST_ACC: begin
        samp_inc  = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_EPOCH_END: begin
        if (sample_cnt != '0) state_nxt = ST_UPDATE;
        else                  epoch_check = 1'b1;
      end
      ST_UPDATE: epoch_check = 1'b1;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    if (epoch_check) begin
      if (epoch_last) begin
        state_nxt = ST_DONE;
      end else begin
        epoch_inc = 1'b1;
        state_nxt = ST_INIT;
      end
    end
  end

  always_comb begin
    ready     = (state == ST_IDLE) || (state == ST_ARM);
    busy      = !ready;
    init_dl   = (state == ST_INIT);
    init_ec   = (state == ST_INIT);
    next      = (state == ST_REQ);
    clr_mac   = (state == ST_REQ);
    en_mac    = (state == ST_MAC);
    en_err    = (state == ST_ERR);
    en_acc    = (state == ST_ACC);
    en_update = (state == ST_UPDATE);
    done      = (state == ST_DONE);
  end

endmodule

// File: tb/tb_regression_train_sequencer.sv
// Cycle-locked check of the sequencer against a scenario model that expands
// per-epoch sample counts into an expected per-cycle strobe/counter trace.
module tb_regression_train_sequencer;

  localparam int NF = 4;
  localparam int NE = 3;

  // {ready,busy,init_dl,init_ec,next,clr_mac,en_mac,en_err,en_acc,en_update,done}
  localparam logic [10:0] O_IDLE = 11'b10000000000;
  localparam logic [10:0] O_INIT = 11'b01110000000;
  localparam logic [10:0] O_REQ  = 11'b01001100000;
  localparam logic [10:0] O_WAIT = 11'b01000000000;
  localparam logic [10:0] O_MAC  = 11'b01000010000;
  localparam logic [10:0] O_ERR  = 11'b01000001000;
  localparam logic [10:0] O_ACC  = 11'b01000000100;
  localparam logic [10:0] O_EEND = 11'b01000000000;
  localparam logic [10:0] O_UPD  = 11'b01000000010;
  localparam logic [10:0] O_DONE = 11'b01000000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, eof = 1'b0, data_valid = 1'b0;
  logic       ready, busy, init_dl, init_ec, next, clr_mac, en_mac;
  logic       en_err, en_acc, en_update, done;
  logic [1:0] feat_idx;
  logic [9:0] sample_cnt;
  logic [1:0] epoch_idx;
  logic [10:0] outs;

  regression_train_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .eof       (eof),
    .data_valid(data_valid),
    .ready     (ready),
    .busy      (busy),
    .init_dl   (init_dl),
    .init_ec   (init_ec),
    .next      (next),
    .clr_mac   (clr_mac),
    .en_mac    (en_mac),
    .feat_idx  (feat_idx),
    .en_err    (en_err),
    .en_acc    (en_acc),
    .en_update (en_update),
    .done      (done),
    .sample_cnt(sample_cnt),
    .epoch_idx (epoch_idx)
  );

  always #5 clk = ~clk;

  assign outs = {ready, busy, init_dl, init_ec, next, clr_mac, en_mac,
                 en_err, en_acc, en_update, done};

  typedef struct {
    logic [10:0] strb;
    int          feat;
    int          samp;
    int          epoch;
    bit          chk_samp;
    bit          st;
    bit          eo;
    bit          dv;
  } rec_t;

  rec_t q[$];
  int   m_samp  = 0;
  int   m_epoch = 0;
  int   n_asr   = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(1, 0));
  endfunction

  function automatic void push(logic [10:0] strb, int feat, bit chk_samp,
                               bit st, bit eo, bit dv);
    rec_t r;
    r.strb = strb; r.feat = feat; r.samp = m_samp; r.epoch = m_epoch;
    r.chk_samp = chk_samp; r.st = st; r.eo = eo; r.dv = dv;
    q.push_back(r);
  endfunction

  // Inputs are don't-care outside WAIT and while busy, so they get random noise.
  function automatic void push_noise(logic [10:0] strb, int feat);
    push(strb, feat, 1'b1, rb(), rb(), rb());
  endfunction

  function automatic void push_stall(int st_lo, int st_hi);
    int n;
    n = $urandom_range(st_hi, st_lo);
    for (int k = 0; k < n; k++) push(O_WAIT, 0, 1'b1, rb(), 1'b0, 1'b0);
  endfunction

  // Expected trace for one run: ns[e] samples in epoch e.
  function automatic void gen_run(int ns[NE], int n_start, int st_lo, int st_hi, bit abort);
    for (int i = 0; i < n_start; i++) push(O_IDLE, 0, 1'b1, 1'b1, rb(), rb());
    push(O_IDLE, 0, 1'b1, 1'b0, rb(), rb());
    for (int e = 0; e < NE; e++) begin
      m_epoch = e;
      push(O_INIT, 0, 1'b0, rb(), rb(), rb());
      m_samp = 0;
      for (int s = 0; s < ns[e]; s++) begin
        push_noise(O_REQ, 0);
        push_stall(st_lo, st_hi);
        push(O_WAIT, 0, 1'b1, rb(), rb(), 1'b1);
        for (int f = 0; f < NF; f++) begin
          if (abort && f == 2) return;
          push_noise(O_MAC, f);
        end
        push_noise(O_ERR, 0);
        push_noise(O_ACC, 0);
        m_samp++;
      end
      push_noise(O_REQ, 0);
      push_stall(st_lo, st_hi);
      push(O_WAIT, 0, 1'b1, rb(), 1'b1, 1'b0);
      push_noise(O_EEND, 0);
      if (m_samp != 0) push_noise(O_UPD, 0);
    end
    push_noise(O_DONE, 0);
  endfunction

  task automatic play();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      chk("strobes", 32'(outs), 32'(r.strb));
      chk("feat_idx", 32'(feat_idx), r.feat);
      chk("epoch_idx", 32'(epoch_idx), r.epoch);
      if (r.chk_samp) chk("sample_cnt", 32'(sample_cnt), r.samp);
      start      = r.st;
      eof        = r.eo;
      data_valid = r.dv;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_outs"}, 32'(outs), 32'(O_IDLE));
    chk({tag, "_feat"}, 32'(feat_idx), 0);
    chk({tag, "_samp"}, 32'(sample_cnt), 0);
    chk({tag, "_epoch"}, 32'(epoch_idx), 0);
  endtask

  initial begin
    int ns[NE];

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_reset");

    gen_run('{2, 1, 3}, 3, 0, 0, 1'b0); play();
    gen_run('{1, 1, 1}, 1, 0, 0, 1'b0); play();
    gen_run('{2, 1, 1}, 2, 5, 5, 1'b0); play();
    gen_run('{0, 0, 0}, 1, 0, 0, 1'b0); play();
    gen_run('{0, 2, 0}, 1, 0, 2, 1'b0); play();

    // Abort in the middle of the MAC sweep.
    gen_run('{2, 1, 1}, 2, 0, 1, 1'b1); play();
    chk("abort_feat", 32'(feat_idx), 2);
    chk("abort_en_mac", 32'(en_mac), 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("abort_reset");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(outs), 32'(O_IDLE));
    end
    reset  = 1'b1;
    m_samp = 0;
    m_epoch = 0;
    start = 1'b0; eof = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("abort_idle");
    gen_run('{1, 2, 1}, 1, 0, 1, 1'b0); play();

    for (int r = 0; r < 5; r++) begin
      for (int e = 0; e < NE; e++) ns[e] = $urandom_range(3, 0);
      gen_run(ns, $urandom_range(3, 1), 0, 3, 1'b0);
      play();
    end

    for (int k = 0; k < 2; k++) push(O_IDLE, 0, 1'b1, 1'b0, rb(), rb());
    play();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end

endmodule
